// File: rtl/irq_bus_if.sv
// Peripheral register bus between the CPU-side decoder and the interrupt controller.
interface irq_bus_if;
  logic       R_W_n;         // registered read/write strobe, 1 = read
  logic [2:0] reg_addr_i;    // write address (CPU address delayed one clock)
  logic [2:0] reg_addr_r_i;  // read address (current CPU address)
  logic [7:0] data_i;        // write data
  logic       irq_cs;        // chip select from the address decoder
  logic [7:0] data_o;        // registered read data

  modport master (
    output R_W_n, reg_addr_i, reg_addr_r_i, data_i, irq_cs,
    input  data_o
  );

  modport slave (
    input  R_W_n, reg_addr_i, reg_addr_r_i, data_i, irq_cs,
    output data_o
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt aggregator: latches up to 8 sources as edge or level, masks them
// and drives a single registered active-high IRQ into the CPU.
module irq_controller #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  irq_bus_if.slave   bus,
  input  logic [7:0] src_i,
  output logic       irq_o
);

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] IMPL_MASK = DW'((16'd1 << NUM_SRC) - 16'd1);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_SWSET   = 3'd5;

  logic [DW-1:0] pending, enable, mode, src_d;
  logic [DW-1:0] pending_next, enable_next, mode_next;
  logic [DW-1:0] w1c, swset, rise, active, vector, rd_data;
  logic [2:0]    vec_idx;
  logic          wr_en;

  // Write decode and next-state for the control/status registers
  always_comb begin
    wr_en       = bus.irq_cs & ~bus.R_W_n;
    w1c         = '0;
    swset       = '0;
    enable_next = enable;
    mode_next   = mode;
    if (wr_en) begin
      case (bus.reg_addr_i)
        ADDR_PENDING: w1c         = bus.data_i & IMPL_MASK;
        ADDR_ENABLE:  enable_next = bus.data_i & IMPL_MASK;
        ADDR_MODE:    mode_next   = bus.data_i & IMPL_MASK;
        ADDR_SWSET:   swset       = bus.data_i & IMPL_MASK;
        default:      ;
      endcase
    end
    // Edge bits: set (hardware or software) wins over W1C so no edge is lost.
    // Level bits simply track the source.
    rise         = src_i & ~src_d & IMPL_MASK;
    pending_next = (mode & ((pending & ~w1c) | rise | swset))
                 | (~mode & src_i & IMPL_MASK);
  end

  // ACTIVE, VECTOR and read-data mux
  always_comb begin
    active  = pending & enable;
    vec_idx = 3'd0;
    for (int k = int'(DW) - 1; k >= 0; k--) begin
      if (active[k]) vec_idx = 3'(k);
    end
    vector = {|active, 4'b0000, vec_idx};
    case (bus.reg_addr_r_i)
      ADDR_PENDING: rd_data = pending;
      ADDR_ENABLE:  rd_data = enable;
      ADDR_MODE:    rd_data = mode;
      ADDR_ACTIVE:  rd_data = active;
      ADDR_VECTOR:  rd_data = vector;
      default:      rd_data = '0;
    endcase
  end

  // State, read data and IRQ registers; IRQ reflects registered PENDING & ENABLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= IMPL_MASK;
      src_d      <= '0;
      irq_o      <= 1'b0;
      bus.data_o <= '0;
    end else begin
      pending    <= pending_next;
      enable     <= enable_next;
      mode       <= mode_next;
      src_d      <= src_i;
      irq_o      <= |active;
      bus.data_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       irq;
  logic [7:0] rd;
  int         n_vec = 0;
  int         n_err = 0;

  irq_bus_if bus ();

  irq_controller #(.NUM_SRC(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .src_i (src),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  // Registered read: address applied now, data valid after the next edge
  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    bus.reg_addr_r_i = a;
    @(negedge clk);
    d = bus.data_o;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    bus.irq_cs     = 1'b1;
    bus.R_W_n      = 1'b0;
    bus.reg_addr_i = a;
    bus.data_i     = d;
    @(negedge clk);
    bus.irq_cs     = 1'b0;
    bus.R_W_n      = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_regs [5];
    exp_regs = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
    n_vec++;
    if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL reset_data_o got %h want 00", bus.data_o); end
    for (int i = 0; i < 5; i++) begin
      read_reg(3'(i), rd);
      n_vec++;
      if (rd !== exp_regs[i]) begin n_err++; $display("FAIL reset_reg%0d got %h want %h", i, rd, exp_regs[i]); end
    end
  endtask

  task automatic test_edge_pulse();
    write_reg(3'd1, 8'h04);
    src = 8'h04;
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_latency got %b want 0", irq); end
    src = 8'h00;
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_rise got %b want 1", irq); end
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h04) begin n_err++; $display("FAIL edge_pending got %h want 04", rd); end
    read_reg(3'd4, rd);
    n_vec++;
    if (rd !== 8'h82) begin n_err++; $display("FAIL edge_vector got %h want 82", rd); end
    write_reg(3'd0, 8'h04);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL w1c_irq_hold got %b want 1", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq_drop got %b want 0", irq); end
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL w1c_pending got %h want 00", rd); end
  endtask

  task automatic test_level();
    write_reg(3'd2, 8'h00);
    write_reg(3'd1, 8'h01);
    src = 8'h01;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL level_irq got %b want 1", irq); end
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h01) begin n_err++; $display("FAIL level_pending got %h want 01", rd); end
    write_reg(3'd0, 8'h01);
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h01) begin n_err++; $display("FAIL level_w1c_ignored got %h want 01", rd); end
    src = 8'h00;
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL level_irq_lag got %b want 1", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL level_irq_drop got %b want 0", irq); end
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL level_pending_clear got %h want 00", rd); end
  endtask

  task automatic test_set_beats_clear();
    write_reg(3'd2, 8'hFF);
    write_reg(3'd1, 8'h08);
    src = 8'h08;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq_pre got %b want 1", irq); end
    // New rising edge and W1C on the same clock edge
    src            = 8'h08;
    bus.irq_cs     = 1'b1;
    bus.R_W_n      = 1'b0;
    bus.reg_addr_i = 3'd0;
    bus.data_i     = 8'h08;
    @(negedge clk);
    bus.irq_cs = 1'b0;
    bus.R_W_n  = 1'b1;
    src        = 8'h00;
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h08) begin n_err++; $display("FAIL race_pending got %h want 08", rd); end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq_post got %b want 1", irq); end
    write_reg(3'd0, 8'h08);
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL race_cleanup_irq got %b want 0", irq); end
  endtask

  task automatic test_masking_priority();
    write_reg(3'd1, 8'h00);
    src = 8'h22;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b want 0", irq); end
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h22) begin n_err++; $display("FAIL mask_pending got %h want 22", rd); end
    read_reg(3'd3, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL mask_active got %h want 00", rd); end
    write_reg(3'd1, 8'h20);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL enable_irq_lag got %b want 0", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL enable_irq_rise got %b want 1", irq); end
    read_reg(3'd4, rd);
    n_vec++;
    if (rd !== 8'h85) begin n_err++; $display("FAIL vector_src5 got %h want 85", rd); end
    write_reg(3'd1, 8'h22);
    read_reg(3'd4, rd);
    n_vec++;
    if (rd !== 8'h81) begin n_err++; $display("FAIL vector_src1 got %h want 81", rd); end
    read_reg(3'd3, rd);
    n_vec++;
    if (rd !== 8'h22) begin n_err++; $display("FAIL active_both got %h want 22", rd); end
    write_reg(3'd1, 8'h00);
    write_reg(3'd0, 8'h22);
  endtask

  task automatic test_swset_and_reset();
    write_reg(3'd1, 8'h80);
    write_reg(3'd5, 8'h80);
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h80) begin n_err++; $display("FAIL swset_pending got %h want 80", rd); end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL swset_irq got %b want 1", irq); end
    read_reg(3'd5, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL swset_readback got %h want 00", rd); end
    write_reg(3'd7, 8'hFF);
    read_reg(3'd7, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL reg7_read got %h want 00", rd); end
    bus.reg_addr_r_i = 3'd2;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq got %b want 0", irq); end
    n_vec++;
    if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL midreset_data_o got %h want 00", bus.data_o); end
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL midreset_pending got %h want 00", rd); end
    read_reg(3'd1, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL midreset_enable got %h want 00", rd); end
    read_reg(3'd2, rd);
    n_vec++;
    if (rd !== 8'hFF) begin n_err++; $display("FAIL midreset_mode got %h want FF", rd); end
  endtask

  task automatic test_held_through_reset();
    src = 8'h10;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h10) begin n_err++; $display("FAIL held_first_edge got %h want 10", rd); end
    write_reg(3'd0, 8'h10);
    read_reg(3'd0, rd);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL held_no_reedge got %h want 00", rd); end
    src = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b1;
    src              = 8'h00;
    bus.R_W_n        = 1'b1;
    bus.reg_addr_i   = 3'd0;
    bus.reg_addr_r_i = 3'd0;
    bus.data_i       = 8'h00;
    bus.irq_cs       = 1'b0;
    @(negedge clk);
    test_reset();
    test_edge_pulse();
    test_level();
    test_set_beats_clear();
    test_masking_priority();
    test_swset_and_reset();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
